// File: rtl/bcd_display_scan.sv
// ============================================================================
// bcd_display_scan
// ----------------------------------------------------------------------------
// Drives a 2-digit multiplexed 7-segment display from the two-digit BCD
// up/down counter.  A slot counter walks a four-slot frame
//     BLANK1 -> DIG0 -> BLANK0 -> DIG1 -> BLANK1 ...
// where the blank slots keep every output off so the previous digit cannot
// ghost into the next one while the anode drivers switch over.
//
// Both digits are snapshotted on the DIG0 entry edge, so one frame always
// shows a single consistent counter value.  The one-cycle carry/borrow flag
// is stretched into a decimal-point flash on the tens digit that lasts for
// FLASH_FRAMES full DIG1 slots after the most recent carry rising edge.
//
// Optional build macro:
//   LZB_EN  - leading-zero blanking.  When the held tens digit is 0, its
//             segments stay off for the DIG1 slot; its anode is enabled only
//             if the decimal point has to be shown in that slot.
//
// Parameters:
//   REFRESH_DIV    clk cycles per lit digit slot (>= 2)
//   BLANK_DIV      clk cycles per blank slot (>= 1)
//   FLASH_FRAMES   DIG1 slots with dp lit after a carry rising edge (>= 1)
//   SEG_ACTIVE_LOW 1: seg/dp/an active-low, 0: active-high
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   q0     in   [3:0] units BCD digit
//   q1     in   [3:0] tens BCD digit
//   c      in   carry/borrow level from the counter (may be a 1-cycle pulse)
//   seg    out  [6:0] segments {g,f,e,d,c,b,a}, registered
//   dp     out  decimal point (tens digit only), registered
//   an     out  [1:0] digit enables, an[0] = units, an[1] = tens, registered
// ============================================================================
module bcd_display_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_DIV      = 500,
    parameter int FLASH_FRAMES   = 50,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q0,
    input  logic [3:0] q1,
    input  logic       c,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MAX_DIV = (REFRESH_DIV > BLANK_DIV) ? REFRESH_DIV : BLANK_DIV;
    localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int FL_W    = $clog2(FLASH_FRAMES + 1);
    localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_DIV - 1);
    localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_FRAMES);

    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        DIG0   = 2'd1,
        BLANK0 = 2'd2,
        DIG1   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers: BCD decode and conversion from active-high pattern to pin level
    // ------------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;     // non-BCD codes render as "-"
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_lvl(input logic [6:0] p);
        return ACT_LOW ? ~p : p;
    endfunction

    function automatic logic [1:0] an_lvl(input logic [1:0] p);
        return ACT_LOW ? ~p : p;
    endfunction

    function automatic logic bit_lvl(input logic p);
        return ACT_LOW ? ~p : p;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [3:0]        h0_reg;
    logic [3:0]        h1_reg;
    logic [FL_W-1:0]   flash_cnt_reg;
    logic              c_d_reg;
    logic              dp_counts_reg;   // current DIG1 slot consumes one flash frame
    logic [6:0]        seg_reg;
    logic              dp_reg;
    logic [1:0]        an_reg;

    // ------------------------------------------------------------------------
    // Digit decoders: [0] live units input (used at the snapshot edge),
    // [1] held units digit, [2] held tens digit.
    // ------------------------------------------------------------------------
    logic [3:0] dig_src [3];
    logic [6:0] dig_pat [3];

    assign dig_src[0] = q0;
    assign dig_src[1] = h0_reg;
    assign dig_src[2] = h1_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_decode
            assign dig_pat[gi] = decode(dig_src[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Slot timing and carry edge detection
    // ------------------------------------------------------------------------
    logic slot_is_digit;
    logic slot_last;
    logic c_rise;
    logic dig1_exit;
    logic flash_live;

    assign slot_is_digit = (state_reg == DIG0) || (state_reg == DIG1);
    assign slot_last     = (cnt_reg == (slot_is_digit ? REF_LAST : BLK_LAST));
    assign c_rise        = c & ~c_d_reg;
    assign dig1_exit     = (state_reg == DIG1) && slot_last;
    assign flash_live    = (flash_cnt_reg != '0);

    // ------------------------------------------------------------------------
    // Scan FSM, snapshot, flash stretcher and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= BLANK1;
            cnt_reg       <= '0;
            h0_reg        <= 4'd0;
            h1_reg        <= 4'd0;
            flash_cnt_reg <= '0;
            c_d_reg       <= 1'b0;
            dp_counts_reg <= 1'b0;
            seg_reg       <= seg_lvl(7'h00);
            dp_reg        <= bit_lvl(1'b0);
            an_reg        <= an_lvl(2'b00);
        end else begin
            c_d_reg <= c;

            // A new carry edge always reloads; otherwise a DIG1 slot that
            // showed dp for its whole length uses up one frame of the flash.
            if (c_rise) begin
                flash_cnt_reg <= FL_LOAD;
            end else if (dig1_exit && dp_counts_reg && flash_live) begin
                flash_cnt_reg <= flash_cnt_reg - 1'b1;
            end

            // A slot in which a reload happens is not a full slot after the
            // latest edge, so it must not consume a frame of the new flash.
            if (c_rise) begin
                dp_counts_reg <= 1'b0;
            end

            if (slot_last) begin
                cnt_reg <= '0;
                case (state_reg)
                    BLANK1: begin
                        state_reg <= DIG0;
                        h0_reg    <= q0;
                        h1_reg    <= q1;
                        seg_reg   <= seg_lvl(dig_pat[0]);
                        an_reg    <= an_lvl(2'b01);
                        dp_reg    <= bit_lvl(1'b0);
                    end
                    DIG0: begin
                        state_reg <= BLANK0;
                        seg_reg   <= seg_lvl(7'h00);
                        an_reg    <= an_lvl(2'b00);
                        dp_reg    <= bit_lvl(1'b0);
                    end
                    BLANK0: begin
                        state_reg     <= DIG1;
                        dp_reg        <= bit_lvl(flash_live);
                        dp_counts_reg <= flash_live && !c_rise;
`ifdef LZB_EN
                        if (h1_reg == 4'd0) begin
                            // Blanked leading zero: anode only for the dp.
                            seg_reg <= seg_lvl(7'h00);
                            an_reg  <= an_lvl(flash_live ? 2'b10 : 2'b00);
                        end else begin
                            seg_reg <= seg_lvl(dig_pat[2]);
                            an_reg  <= an_lvl(2'b10);
                        end
`else
                        seg_reg <= seg_lvl(dig_pat[2]);
                        an_reg  <= an_lvl(2'b10);
`endif
                    end
                    default: begin  // DIG1
                        state_reg <= BLANK1;
                        seg_reg   <= seg_lvl(7'h00);
                        an_reg    <= an_lvl(2'b00);
                        dp_reg    <= bit_lvl(1'b0);
                    end
                endcase
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                // Inside DIG0 the segments are re-asserted from the snapshot,
                // which holds exactly the value decoded at the entry edge.
                if (state_reg == DIG0) begin
                    seg_reg <= seg_lvl(dig_pat[1]);
                end
            end
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// ============================================================================
// tb_bcd_display_scan
// ----------------------------------------------------------------------------
// Scoreboard bench for bcd_display_scan.  The stimulus process drives inputs
// on the falling edge, and after each rising edge evaluates a time-based
// reference model (frame position from cycles since reset, carry flash as
// "DIG1 entries since the last carry edge") and queues the expected output.
// A monitor process pops one expectation per falling edge and compares.
// ============================================================================
module tb_bcd_display_scan;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int F     = 3;
    localparam int SAL   = 0;
    localparam int FRAME = 2 * (R + B);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       c;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;

    always #5 clk = ~clk;

    bcd_display_scan #(
        .REFRESH_DIV   (R),
        .BLANK_DIV     (B),
        .FLASH_FRAMES  (F),
        .SEG_ACTIVE_LOW(SAL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .q0   (q0),
        .q1   (q1),
        .c    (c),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    // Expected output after a clock edge, in active-high form.
    // kind: 0 = mid-slot, 1 = DIG0 entry, 2 = DIG1 entry, 3 = blank/reset
    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] an;
        int         kind;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   pushed = 0;
    int   cyc = 0;

    // Reference model state
    int         n = 0;           // cycles since the last reset edge
    bit         have_rise = 0;   // a carry edge has been seen since reset
    int         ent_since = 0;   // DIG1 entries since the last carry edge
    bit         prev_c = 0;
    logic [3:0] h1m = 4'd0;
    logic [6:0] m_seg = 7'h00;
    logic       m_dp = 1'b0;
    logic [1:0] m_an = 2'b00;

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return tbl[d];
    endfunction

    // One clock: apply inputs, let the edge happen, model it, queue result.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic cc);
        int   pos;
        bit   rise;
        bit   lit;
        exp_t e;
        @(negedge clk);
        reset = r; q0 = a; q1 = b; c = cc;
        @(posedge clk);
        cyc++;
        e.kind = 0;
        if (r) begin
            n = 0; have_rise = 0; prev_c = 0; h1m = 4'd0;
            m_seg = 7'h00; m_dp = 1'b0; m_an = 2'b00;
            e.kind = 3;
        end else begin
            n++;
            pos  = n % FRAME;
            rise = cc && !prev_c;
            prev_c = cc;
            if (pos == B) begin
                h1m = b;
                m_seg = dec(a); m_an = 2'b01; m_dp = 1'b0;
                e.kind = 1;
            end else if (pos == 0 || pos == B + R) begin
                m_seg = 7'h00; m_an = 2'b00; m_dp = 1'b0;
                e.kind = 3;
            end else if (pos == 2 * B + R) begin
                ent_since++;
                lit = have_rise && (ent_since <= F);
                m_dp = lit;
`ifdef LZB_EN
                if (h1m == 4'd0) begin
                    m_seg = 7'h00; m_an = lit ? 2'b10 : 2'b00;
                end else begin
                    m_seg = dec(h1m); m_an = 2'b10;
                end
`else
                m_seg = dec(h1m); m_an = 2'b10;
`endif
                e.kind = 2;
            end
            if (rise) begin
                have_rise = 1;
                ent_since = 0;
            end
        end
        e.seg = m_seg; e.dp = m_dp; e.an = m_an; e.cyc = cyc;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Monitor: compare pin levels against the queued expectation.
    initial begin
        exp_t       e;
        logic [6:0] rs;
        logic       rd;
        logic [1:0] ra;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                rs = (SAL != 0) ? ~e.seg : e.seg;
                rd = (SAL != 0) ? ~e.dp  : e.dp;
                ra = (SAL != 0) ? ~e.an  : e.an;
                tests++;
                if (seg !== rs || dp !== rd || an !== ra) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                             e.cyc, an, seg, dp, ra, rs, rd);
                end else if (e.kind == 1 || e.kind == 2) begin
                    $display("[TB] cyc=%0d %s an=%b seg=%h dp=%b", e.cyc,
                             (e.kind == 1) ? "DIG0" : "DIG1", an, seg, dp);
                end
            end
        end
    end

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic       cl;
        reset = 1'b0; q0 = 4'd0; q1 = 4'd0; c = 1'b0;

        // Basic scan with a held value.
        step(1'b1, 4'd7, 4'd3, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 4'd7, 4'd3, 1'b0);
        // Units digit changes mid-frame.
        for (int i = 0; i < 24; i++) step(1'b0, 4'd2, 4'd3, 1'b0);
        // Non-BCD tens digit.
        for (int i = 0; i < 24; i++) step(1'b0, 4'd2, 4'hC, 1'b0);
        // Carry pulse, then a second pulse while the flash is active.
        step(1'b0, 4'd2, 4'd3, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd2, 4'd3, 1'b0);
        step(1'b0, 4'd2, 4'd3, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b0, 4'd2, 4'd3, 1'b0);
        // Leading zero with and without flash.
        for (int i = 0; i < 24; i++) step(1'b0, 4'd5, 4'd0, 1'b0);
        step(1'b0, 4'd5, 4'd0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 4'd5, 4'd0, 1'b0);
        // Reset in the middle of a flashed frame.
        step(1'b0, 4'd9, 4'd1, 1'b1);
        for (int i = 0; i < 21; i++) step(1'b0, 4'd9, 4'd1, 1'b0);
        step(1'b1, 4'd4, 4'd1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 4'd4, 4'd1, 1'b0);

        // Randomized traffic.
        a = 4'd0; b = 4'd0; cl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0)  a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)  cl = ($urandom_range(0, 11) == 0);
            step(($urandom_range(0, 299) == 0), a, b, cl);
        end

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending required 0 (pushed %0d)",
                     exp_q.size(), pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
